// File: rtl/alu_issue.sv
// Operand-issue / result-capture stage ahead of the multi-cycle MIPS ALU.
// Latches an instruction, decodes it to ALU Ctrl + operands, then captures C/Compare/overflow.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_c,
    input  logic        alu_compare,
    output logic [31:0] result,
    output logic        cmp_flag,
    output logic        is_branch,
    output logic        ovf,
    output logic        illegal,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_ADDU = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3;
    localparam logic [4:0] ALUOp_SUBU = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_XOR  = 5'd7;
    localparam logic [4:0] ALUOp_NOR  = 5'd8;
    localparam logic [4:0] ALUOp_SLT  = 5'd9;
    localparam logic [4:0] ALUOp_SLTU = 5'd10;
    localparam logic [4:0] ALUOp_SEQ  = 5'd11;
    localparam logic [4:0] ALUOp_SNE  = 5'd12;
    localparam logic [4:0] ALUOp_LEZ  = 5'd13;
    localparam logic [4:0] ALUOp_GTZ  = 5'd14;
    localparam logic [4:0] ALUOp_LTZ  = 5'd15;
    localparam logic [4:0] ALUOp_GEZ  = 5'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] instr_r;
    logic [31:0] rs_r;
    logic [31:0] rt_r;
    logic        dec_branch_r;
    logic        dec_illegal_r;

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_field_s;
    logic [15:0] imm_s;
    logic [31:0] sext_s;
    logic [31:0] zext_s;
    logic [4:0]  ctrl_s;
    logic [31:0] b_s;
    logic        branch_s;
    logic        illegal_s;
    logic        ovf_s;
    logic        unused_rs_field_s;

    assign op_s              = instr_r[31:26];
    assign rt_field_s        = instr_r[20:16];
    assign imm_s             = instr_r[15:0];
    assign funct_s           = instr_r[5:0];
    assign sext_s            = {{16{imm_s[15]}}, imm_s};
    assign zext_s            = {16'h0000, imm_s};
    assign unused_rs_field_s = ^instr_r[25:21];

    // Opcode/funct decode into ALU control, operand B and branch/illegal tags
    always_comb begin
        ctrl_s    = ALUOp_NOP;
        b_s       = 32'd0;
        branch_s  = 1'b0;
        illegal_s = 1'b0;
        case (op_s)
            6'h00: begin
                b_s = rt_r;
                case (funct_s)
                    6'h20:   ctrl_s = ALUOp_ADD;
                    6'h21:   ctrl_s = ALUOp_ADDU;
                    6'h22:   ctrl_s = ALUOp_SUB;
                    6'h23:   ctrl_s = ALUOp_SUBU;
                    6'h24:   ctrl_s = ALUOp_AND;
                    6'h25:   ctrl_s = ALUOp_OR;
                    6'h26:   ctrl_s = ALUOp_XOR;
                    6'h27:   ctrl_s = ALUOp_NOR;
                    6'h2A:   ctrl_s = ALUOp_SLT;
                    6'h2B:   ctrl_s = ALUOp_SLTU;
                    default: begin
                        b_s       = 32'd0;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            6'h08: begin ctrl_s = ALUOp_ADD;  b_s = sext_s; end
            6'h09: begin ctrl_s = ALUOp_ADDU; b_s = sext_s; end
            6'h0A: begin ctrl_s = ALUOp_SLT;  b_s = sext_s; end
            6'h0B: begin ctrl_s = ALUOp_SLTU; b_s = sext_s; end
            6'h0C: begin ctrl_s = ALUOp_AND;  b_s = zext_s; end
            6'h0D: begin ctrl_s = ALUOp_OR;   b_s = zext_s; end
            6'h0E: begin ctrl_s = ALUOp_XOR;  b_s = zext_s; end
            6'h0F: begin ctrl_s = ALUOp_NOP;  b_s = {imm_s, 16'h0000}; end
            6'h23, 6'h2B: begin ctrl_s = ALUOp_ADDU; b_s = sext_s; end
            6'h04: begin ctrl_s = ALUOp_SEQ; b_s = rt_r; branch_s = 1'b1; end
            6'h05: begin ctrl_s = ALUOp_SNE; b_s = rt_r; branch_s = 1'b1; end
            6'h06: begin ctrl_s = ALUOp_LEZ; branch_s = 1'b1; end
            6'h07: begin ctrl_s = ALUOp_GTZ; branch_s = 1'b1; end
            6'h01: begin
                if (rt_field_s == 5'd0) begin
                    ctrl_s   = ALUOp_LTZ;
                    branch_s = 1'b1;
                end else if (rt_field_s == 5'd1) begin
                    ctrl_s   = ALUOp_GEZ;
                    branch_s = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Signed overflow from the operands actually presented to the ALU this cycle
    always_comb begin
        ovf_s = 1'b0;
        if (alu_ctrl == ALUOp_ADD) begin
            ovf_s = (alu_a[31] == alu_b[31]) && (alu_c[31] != alu_a[31]);
        end else if (alu_ctrl == ALUOp_SUB) begin
            ovf_s = (alu_a[31] != alu_b[31]) && (alu_c[31] != alu_a[31]);
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Issue FSM: latch, drive operands, capture ALU outputs, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            instr_r       <= 32'd0;
            rs_r          <= 32'd0;
            rt_r          <= 32'd0;
            dec_branch_r  <= 1'b0;
            dec_illegal_r <= 1'b0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_ctrl      <= ALUOp_NOP;
            result        <= 32'd0;
            cmp_flag      <= 1'b0;
            is_branch     <= 1'b0;
            ovf           <= 1'b0;
            illegal       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        instr_r <= instr;
                        rs_r    <= rs_data;
                        rt_r    <= rt_data;
                        busy    <= 1'b1;
                        state_r <= DECODE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                DECODE: begin
                    alu_a         <= rs_r;
                    alu_b         <= b_s;
                    alu_ctrl      <= ctrl_s;
                    dec_branch_r  <= branch_s;
                    dec_illegal_r <= illegal_s;
                    state_r       <= EXEC;
                end
                EXEC: begin
                    result    <= dec_branch_r ? 32'd0 : alu_c;
                    cmp_flag  <= dec_branch_r ? alu_compare : 1'b0;
                    is_branch <= dec_branch_r;
                    illegal   <= dec_illegal_r;
                    ovf       <= ovf_s;
                    done      <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with a behavioural ALU stub and
// an instruction-level reference model.
module tb_alu_issue;

    localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_ADDU = 5'd2, OP_SUB = 5'd3;
    localparam logic [4:0] OP_SUBU = 5'd4, OP_AND = 5'd5,  OP_OR = 5'd6,   OP_XOR = 5'd7;
    localparam logic [4:0] OP_NOR = 5'd8,  OP_SLT = 5'd9,  OP_SLTU = 5'd10, OP_SEQ = 5'd11;
    localparam logic [4:0] OP_SNE = 5'd12, OP_LEZ = 5'd13, OP_GTZ = 5'd14, OP_LTZ = 5'd15;
    localparam logic [4:0] OP_GEZ = 5'd16;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] instr, rs_data, rt_data;
    logic [31:0] alu_a, alu_b, alu_c, result;
    logic [4:0]  alu_ctrl;
    logic        alu_compare, cmp_flag, is_branch, ovf, illegal, busy, done;

    typedef struct {
        logic [31:0] a, b, res;
        logic [4:0]  ctrl;
        logic        cmp, br, ovf, ill;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0, passed = 0, cyc = 0, done_cnt = 0, exp_done = 0;

    alu_issue dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_c(alu_c), .alu_compare(alu_compare),
        .result(result), .cmp_flag(cmp_flag), .is_branch(is_branch),
        .ovf(ovf), .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU operation semantics (NOP passes B through, which is how LUI reaches C)
    function automatic logic [31:0] ref_res(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            OP_ADD, OP_ADDU: return a + b;
            OP_SUB, OP_SUBU: return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_NOP:  return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cmp(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            OP_SEQ: return a == b;
            OP_SNE: return a != b;
            OP_LEZ: return $signed(a) <= 32'sd0;
            OP_GTZ: return $signed(a) >  32'sd0;
            OP_LTZ: return $signed(a) <  32'sd0;
            OP_GEZ: return $signed(a) >= 32'sd0;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_c       = ref_res(alu_ctrl, alu_a, alu_b);
        alu_compare = ref_cmp(alu_ctrl, alu_a, alu_b);
    end

    function automatic logic out_of_range(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [31:0] sx, zx;
        longint sa, sb_v;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e.a = rs; e.b = 32'd0; e.ctrl = OP_NOP; e.res = 32'd0;
        e.cmp = 1'b0; e.br = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.cyc = 0;
        case (ins[31:26])
            6'h00: begin
                e.b = rt;
                case (ins[5:0])
                    6'h20: e.ctrl = OP_ADD;  6'h21: e.ctrl = OP_ADDU;
                    6'h22: e.ctrl = OP_SUB;  6'h23: e.ctrl = OP_SUBU;
                    6'h24: e.ctrl = OP_AND;  6'h25: e.ctrl = OP_OR;
                    6'h26: e.ctrl = OP_XOR;  6'h27: e.ctrl = OP_NOR;
                    6'h2A: e.ctrl = OP_SLT;  6'h2B: e.ctrl = OP_SLTU;
                    default: begin e.ill = 1'b1; e.b = 32'd0; end
                endcase
            end
            6'h08: begin e.ctrl = OP_ADD;  e.b = sx; end
            6'h09: begin e.ctrl = OP_ADDU; e.b = sx; end
            6'h0A: begin e.ctrl = OP_SLT;  e.b = sx; end
            6'h0B: begin e.ctrl = OP_SLTU; e.b = sx; end
            6'h0C: begin e.ctrl = OP_AND;  e.b = zx; end
            6'h0D: begin e.ctrl = OP_OR;   e.b = zx; end
            6'h0E: begin e.ctrl = OP_XOR;  e.b = zx; end
            6'h0F: begin e.ctrl = OP_NOP;  e.b = {ins[15:0], 16'h0000}; end
            6'h23, 6'h2B: begin e.ctrl = OP_ADDU; e.b = sx; end
            6'h04: begin e.ctrl = OP_SEQ; e.b = rt; e.br = 1'b1; end
            6'h05: begin e.ctrl = OP_SNE; e.b = rt; e.br = 1'b1; end
            6'h06: begin e.ctrl = OP_LEZ; e.br = 1'b1; end
            6'h07: begin e.ctrl = OP_GTZ; e.br = 1'b1; end
            6'h01: begin
                if (ins[20:16] == 5'd0) begin e.ctrl = OP_LTZ; e.br = 1'b1; end
                else if (ins[20:16] == 5'd1) begin e.ctrl = OP_GEZ; e.br = 1'b1; end
                else e.ill = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        sa   = longint'($signed(rs));
        sb_v = longint'($signed(e.b));
        if (e.br) e.cmp = ref_cmp(e.ctrl, rs, e.b);
        else      e.res = ref_res(e.ctrl, rs, e.b);
        if (e.ctrl == OP_ADD) e.ovf = out_of_range(sa + sb_v);
        if (e.ctrl == OP_SUB) e.ovf = out_of_range(sa - sb_v);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_ctrl"}, {27'd0, alu_ctrl}, {27'd0, OP_NOP});
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_flags"}, {26'd0, cmp_flag, is_branch, ovf, illegal, busy, done}, 32'd0);
    endtask

    // Scoreboard monitor: pops one expectation per done pulse
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_ctrl", {27'd0, alu_ctrl}, {27'd0, e.ctrl});
                chk("result", result, e.res);
                chk("flags", {28'd0, cmp_flag, is_branch, ovf, illegal}, {28'd0, e.cmp, e.br, e.ovf, e.ill});
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input bit junk);
        exp_t e;
        @(negedge clk);
        start = 1'b1; instr = ins; rs_data = rs; rt_data = rt;
        e = model(ins, rs, rt);
        e.cyc = cyc + 3;
        sb.push_back(e);
        exp_done++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_cycle1", {31'd0, busy}, 32'd1);
            start = junk; instr = $urandom; rs_data = $urandom; rt_data = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rtf, input logic [15:0] imm);
        return {op, 5'd1, rtf, imm};
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fl[10];
        logic [5:0] ol[14];
        logic [31:0] r;
        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        ol = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
               6'h04, 6'h05, 6'h06, 6'h07};
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, r[25:6], fl[$urandom_range(0, 9)]};
            3:       return {6'h00, r[25:0]};
            4:       return {6'h01, r[25:21], 5'($urandom_range(0, 3)), r[15:0]};
            5:       return r;
            default: return {ol[$urandom_range(0, 13)], r[25:0]};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        idle(2);
        chk_reset("reset");
        rst = 1'b0;
        idle(1);

        issue(rtype(6'h20), 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(rtype(6'h21), 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(itype(6'h0D, 5'd0, 16'hFFFF), 32'h1234_0000, 32'h0, 1'b0);
        issue(itype(6'h0F, 5'd0, 16'hABCD), 32'h5555_AAAA, 32'h0, 1'b0);
        issue(itype(6'h04, 5'd2, 16'h0010), 32'd5, 32'd5, 1'b0);
        issue(itype(6'h01, 5'd1, 16'h0004), 32'h8000_0000, 32'h0, 1'b0);
        issue(itype(6'h0A, 5'd0, 16'h0001), 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(itype(6'h0B, 5'd0, 16'h0001), 32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(32'hFC00_0000, 32'h1111_1111, 32'h2222_2222, 1'b1);
        idle(4);
        chk("hold_illegal", {31'd0, illegal}, 32'd1);
        chk("hold_ctrl", {27'd0, alu_ctrl}, {27'd0, OP_NOP});

        // Reset while EXEC is in progress must abort without a done pulse
        @(negedge clk);
        start = 1'b1; instr = rtype(6'h20); rs_data = 32'h0000_0003; rt_data = 32'h0000_0004;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("reset_in_exec");
        rst = 1'b0;
        idle(3);

        for (int n = 0; n < 200; n++) begin
            issue(rand_instr(), rand_val(), rand_val(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(6);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("done_count", done_cnt, exp_done);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and result-capture stage placed directly upstream of the ALU in the multi-cycle MIPS datapath. It latches an instruction word and its two register-file read values. It decodes opcode/funct into the 5-bit ALU control code and drives registered A/B operands and Ctrl into the ALU. It then captures the ALU's C and Compare outputs, plus a derived signed-overflow flag, into holding registers for the main controller.

## Interface
Parameters:
- none. ALU control codes use the shared `ALUOp_*` constants from `parameter.v`.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- instr  input  32  instruction word, sampled with start
- rs_data  input  32  register-file read of rs, sampled with start
- rt_data  input  32  register-file read of rt, sampled with start
- alu_a  output  32  registered operand A to ALU
- alu_b  output  32  registered operand B to ALU
- alu_ctrl  output  5  registered ALU Ctrl
- alu_c  input  32  ALU result C
- alu_compare  input  1  ALU Compare
- result  output  32  captured ALU result
- cmp_flag  output  1  captured branch condition
- is_branch  output  1  captured op was a branch compare
- ovf  output  1  signed overflow on ADD/ADDI/SUB
- illegal  output  1  unsupported opcode/funct
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse; result/flags valid

## Operation
- States: IDLE -> DECODE -> EXEC -> DONE -> IDLE. There are no other transitions except reset.
- IDLE: when start=1, latch instr, rs_data, rt_data and go to DECODE. Otherwise stay.
- DECODE: register alu_a, alu_b, alu_ctrl from the latched fields. alu_a = rs_data for every op.
- R-type (op 0x00), B = rt. funct mapping:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT, 0x2B SLTU
- I-type, B = imm. Opcode mapping:
  - 0x08 ADDI -> ADD, sext
  - 0x09 ADDIU -> ADDU, sext
  - 0x0A SLTI -> SLT, sext
  - 0x0B SLTIU -> SLTU, sext
  - 0x0C ANDI -> AND, zext
  - 0x0D ORI -> OR, zext
  - 0x0E XORI -> XOR, zext
  - 0x0F LUI -> NOP, B = {imm,16'h0}
  - 0x23 LW and 0x2B SW -> ADDU, sext
- Branches set is_branch:
  - 0x04 BEQ -> SEQ, B = rt
  - 0x05 BNE -> SNE, B = rt
  - 0x06 BLEZ -> LEZ
  - 0x07 BGTZ -> GTZ
  - 0x01 with rt field 0 -> LTZ (BLTZ); rt field 1 -> GEZ (BGEZ)
  - For LEZ/GTZ/LTZ/GEZ, B = 0.
- Any other opcode/funct: alu_ctrl = NOP, B = 0, illegal = 1.
- EXEC: operands are stable for the whole cycle. At the closing edge, capture:
  - result = alu_c, except result = 0 when is_branch
  - cmp_flag = alu_compare when is_branch, else 0
- ovf, computed in EXEC from alu_a/alu_b/alu_c:
  - ADD/ADDI: a[31]==b[31] and c[31]!=a[31]
  - SUB: a[31]!=b[31] and c[31]!=a[31]
  - all other ops: 0
  - result still holds the wrapped sum on overflow; the controller suppresses writeback.
- Arithmetic is modulo 2^32.
- DONE: done = 1 for exactly this cycle, then return to IDLE.
- result, cmp_flag, is_branch, ovf, illegal hold until the next EXEC capture.

## Timing
- Reset values:
  - state IDLE
  - alu_a, alu_b, result = 0
  - alu_ctrl = ALUOp_NOP
  - cmp_flag, is_branch, ovf, illegal, busy, done = 0
- Reset mid-operation aborts at the next edge: the reset values above apply and no done pulse is produced.
- Latency: start sampled at edge 0 -> DECODE in cycle 1 -> EXEC in cycle 2 -> done = 1 in cycle 3. The next start is accepted from cycle 4.
- busy = 1 in cycles 1-3. start while busy is ignored, not queued.
- instr/rs_data/rt_data need only be valid in the start cycle.
- alu_a/alu_b/alu_ctrl change only on the DECODE edge and are otherwise held.

## Test plan
- ADD: rs = 0x7FFFFFFF, rt = 1, funct 0x20 -> done in cycle 3; result 0x80000000; ovf = 1. Repeat with ADDU: ovf = 0.
- ORI and LUI:
  - ORI, rs = 0x12340000, imm 0xFFFF -> alu_b = 0x0000FFFF; result 0x1234FFFF.
  - LUI, imm 0xABCD -> result 0xABCD0000.
- BEQ, rs = rt = 5 -> is_branch = 1, cmp_flag = 1, result 0. Then BGEZ with rs = 0x80000000 -> cmp_flag = 0.
- start re-asserted in cycles 1-3 -> ignored, exactly one done pulse. Back-to-back SLTI then SLTIU with rs = 0xFFFFFFFF, imm 0x0001:
  - SLTI -> result 1
  - SLTIU -> result 0
- Illegal and reset:
  - opcode 0x3F -> illegal = 1, alu_ctrl = NOP, done still pulses in cycle 3.
  - rst asserted in EXEC -> next cycle all outputs at reset values, no done pulse.
